// File: rtl/pts_pkg.sv
// Shared definitions for the burst parallel-to-serial block: FSM state codes and FIFO sizing.
// Optional PARITY state is only reachable when PTS_PARITY_EN is defined.
package pts_pkg;

    typedef logic [1:0] pts_state_t;

    localparam pts_state_t ST_IDLE   = 2'd0;
    localparam pts_state_t ST_SHIFT  = 2'd1;
    localparam pts_state_t ST_PARITY = 2'd2;
    localparam pts_state_t ST_DONE   = 2'd3;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pts_word_fifo.sv
// DATA_W x DEPTH synchronous word FIFO with combinational head read.
// A read and write on the same edge are both honoured, even when full.
module pts_word_fifo
    import pts_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/burst_parallel_to_serial.sv
// Buffers parallel MRAM words and shifts them out as one continuous serial burst.
// Define PTS_PARITY_EN to append an even-parity bit after every word.
//
//   state  | meaning
//   IDLE   | waiting for send_data with a non-empty buffer
//   SHIFT  | driving data bits of the current word
//   PARITY | driving the even-parity bit of the current word (PTS_PARITY_EN only)
//   DONE   | one-cycle end_of_transmission pulse
module burst_parallel_to_serial
    import pts_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              send_data,
    output logic              buf_full,
    output logic              buf_empty,
    output logic              overflow,
    output logic              busy,
    output logic              data_out,
    output logic              data_valid,
    output logic              word_done,
    output logic              end_of_transmission
);

    localparam int                BW       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]     BIT_LAST = BW'(DATA_W - 1);

    pts_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic              start_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] shift_next;
    logic              shift_bit;
`ifdef PTS_PARITY_EN
    logic              parity_q, parity_d;
`endif

    pts_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load),
        .wr_data (data_in),
        .rd_en   (start_word),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign shift_next = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0}
                                         : {1'b0, shift_q[DATA_W-1:1]};
    assign shift_bit  = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        start_word = 1'b0;
`ifdef PTS_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (send_data && !fifo_empty) begin
                    start_word = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
`ifdef PTS_PARITY_EN
                    state_d = ST_PARITY;
`else
                    if (!fifo_empty) begin
                        start_word = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
`endif
                end else begin
                    cnt_d   = cnt_q + BW'(1);
                    shift_d = shift_next;
                end
            end
`ifdef PTS_PARITY_EN
            ST_PARITY: begin
                if (!fifo_empty) begin
                    start_word = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Word boundaries chain straight into the next buffered word with no gap.
        if (start_word) begin
            state_d = ST_SHIFT;
            shift_d = fifo_rd_data;
            cnt_d   = '0;
`ifdef PTS_PARITY_EN
            parity_d = ^fifo_rd_data;
`endif
        end
    end

    // A pop on the same edge frees a slot, so that load is not an overflow.
    assign overflow_d = overflow_q | (load && fifo_full && !start_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`ifdef PTS_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
`ifdef PTS_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign buf_full            = fifo_full;
    assign buf_empty           = fifo_empty;
    assign overflow            = overflow_q;
    assign end_of_transmission = (state_q == ST_DONE);

`ifdef PTS_PARITY_EN
    assign busy       = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign data_valid = busy;
    assign data_out   = (state_q == ST_SHIFT)  ? shift_bit :
                        (state_q == ST_PARITY) ? parity_q  : 1'b0;
    assign word_done  = (state_q == ST_PARITY);
`else
    assign busy       = (state_q == ST_SHIFT);
    assign data_valid = busy;
    assign data_out   = (state_q == ST_SHIFT) ? shift_bit : 1'b0;
    assign word_done  = (state_q == ST_SHIFT) && (cnt_q == BIT_LAST);
`endif

endmodule

// File: tb/tb_burst_parallel_to_serial.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel against a queue model.
module tb_burst_parallel_to_serial;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
`ifdef PTS_PARITY_EN
    localparam int WL = DATA_W + 1;
`else
    localparam int WL = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              send_data;
    logic [DATA_W-1:0] data_in;

    logic m_full, m_empty, m_ovf, m_busy, m_dout, m_dv, m_wd, m_eot;
    logic l_full, l_empty, l_ovf, l_busy, l_dout, l_dv, l_wd, l_eot;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mq[$];
    bit                ovf_m;

    burst_parallel_to_serial #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .send_data(send_data),
        .buf_full(m_full), .buf_empty(m_empty), .overflow(m_ovf), .busy(m_busy),
        .data_out(m_dout), .data_valid(m_dv), .word_done(m_wd), .end_of_transmission(m_eot)
    );

    burst_parallel_to_serial #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .send_data(send_data),
        .buf_full(l_full), .buf_empty(l_empty), .overflow(l_ovf), .busy(l_busy),
        .data_out(l_dout), .data_valid(l_dv), .word_done(l_wd), .end_of_transmission(l_eot)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bit b of a word on the wire: data bits in the chosen order, then the parity bit.
    function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int b, input bit msb);
        if (b >= DATA_W) return ^w;
        return msb ? w[DATA_W-1-b] : w[b];
    endfunction

    task automatic check_idle(input string name);
        logic [7:0] obs;
        logic [5:0] fobs, fexp;
        obs  = {m_dv, m_busy, m_wd, m_eot, m_dout, l_dv, l_wd, l_dout};
        checks++;
        if (obs !== 8'b0) begin
            failures++;
            $display("FAIL %s idle outputs got=%b want=00000000", name, obs);
        end
        fobs = {m_empty, m_full, m_ovf, l_empty, l_full, l_ovf};
        fexp = {2{mq.size() == 0, mq.size() == DEPTH, ovf_m}};
        checks++;
        if (fobs !== fexp) begin
            failures++;
            $display("FAIL %s flags got=%b want=%b", name, fobs, fexp);
        end
    endtask

    task automatic load_word(input logic [DATA_W-1:0] w);
        load    = 1'b1;
        data_in = w;
        tick();
        load    = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(w);
        else ovf_m = 1'b1;
    endtask

    // Starts a burst and checks every cycle through end_of_transmission.
    // ext_cycle = -1 loads ext_word on the start edge; >= 0 loads it after that burst cycle.
    task automatic run_burst(input string name, input bit hold_send, input int ext_cycle,
                             input logic [DATA_W-1:0] ext_word);
        logic [DATA_W-1:0] words[$];
        logic [7:0]        obs, exp;
        int                wi, b;
        words = mq;
        mq.delete();
        send_data = 1'b1;
        if (ext_cycle == -1) begin
            load    = 1'b1;
            data_in = ext_word;
            words.push_back(ext_word);
        end
        tick();
        load = 1'b0;
        if (!hold_send) send_data = 1'b0;
        for (int c = 0; c < words.size() * WL; c++) begin
            wi  = c / WL;
            b   = c % WL;
            exp = {1'b1, 1'b1, b == WL - 1, 1'b0, exp_bit(words[wi], b, 1'b1),
                   1'b1, b == WL - 1, exp_bit(words[wi], b, 1'b0)};
            obs = {m_dv, m_busy, m_wd, m_eot, m_dout, l_dv, l_wd, l_dout};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL %s bit cycle=%0d got=%b want=%b", name, c, obs, exp);
            end
            if (c == ext_cycle) begin
                load    = 1'b1;
                data_in = ext_word;
                words.push_back(ext_word);
            end
            tick();
            load = 1'b0;
        end
        send_data = 1'b0;
        obs = {m_dv, m_busy, m_wd, m_eot, m_dout, l_dv, l_wd, l_eot};
        checks++;
        if (obs !== 8'b0001_0001) begin
            failures++;
            $display("FAIL %s eot got=%b want=00010001", name, obs);
        end
        tick();
        check_idle({name, "_after"});
    endtask

    task automatic test_reset;
        rst = 1'b1; load = 1'b0; send_data = 1'b0; data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        mq.delete();
        ovf_m = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_single_5555;
        load_word(16'h5555);
        check_idle("loaded_5555");
        run_burst("w5555", 1'b0, -2, '0);
    endtask

    task automatic test_four_words;
        load_word(16'hA5A5);
        load_word(16'h0001);
        load_word(16'hFFFF);
        load_word(16'h8000);
        run_burst("four", 1'b0, -2, '0);
    endtask

    task automatic test_empty_send;
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("empty_send");
            tick();
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) load_word(DATA_W'($urandom));
        check_idle("full_after_4");
        load_word(16'hDEAD);
        check_idle("overflow_5th");
        run_burst("ovf_burst", 1'b0, -2, '0);
    endtask

    task automatic test_full_pop_same_edge;
        for (int i = 0; i < 4; i++) load_word(DATA_W'($urandom));
        run_burst("full_pop", 1'b0, -1, 16'h3C3C);
    endtask

    task automatic test_extend;
        load_word(16'h1234);
        run_burst("extend", 1'b1, 3, 16'hC001);
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) load_word(DATA_W'($urandom));
            check_idle("rand_loaded");
            run_burst("rand", bit'($urandom_range(0, 1)), -2, '0);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [DATA_W-1:0] w1;
        w1 = 16'h0F80;
        load_word(16'hAAAA);
        load_word(w1);
        load_word(16'h7777);
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        for (int c = 0; c < WL + 7; c++) tick();
        checks++;
        if ({m_dv, m_dout, l_dout} !== {1'b1, exp_bit(w1, 7, 1'b1), exp_bit(w1, 7, 1'b0)}) begin
            failures++;
            $display("FAIL rst_mid pre-reset bit got=%b%b%b want=1%b%b", m_dv, m_dout, l_dout,
                     exp_bit(w1, 7, 1'b1), exp_bit(w1, 7, 1'b0));
        end
        rst = 1'b1;
        tick();
        mq.delete();
        ovf_m = 1'b0;
        check_idle("rst_mid_1");
        tick();
        rst = 1'b0;
        check_idle("rst_mid_2");
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("rst_then_send");
            tick();
        end
    endtask

    task automatic test_word_0007;
        load_word(16'h0007);
        run_burst("w0007", 1'b0, -2, '0);
    endtask

    initial begin
        test_reset();
        test_single_5555();
        test_four_words();
        test_empty_send();
        test_overflow();
        test_full_pop_same_edge();
        test_extend();
        test_random();
        test_reset_mid_burst();
        test_word_0007();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
